// File: rtl/niu32_pkg.sv
// Shared constants and types for the Niu32 memory arbiter.
package niu32_pkg;

   localparam int WORD_SIZE     = 32;
   localparam int MEM_ADDR_BITS = 13;
   localparam int WIDX_BITS     = MEM_ADDR_BITS - 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } arb_state_t;

   typedef enum logic {
      OWN_IF,
      OWN_D
   } owner_t;

endpackage

// File: rtl/niu32_mem_arbiter_if.sv
// Requester and memory signals of the Niu32 memory arbiter.
// slave = arbiter side, master = requesters plus memory.
interface niu32_mem_arbiter_if;

   logic                                if_req;
   logic [niu32_pkg::WORD_SIZE-1:0]     if_addr;
   logic                                if_gnt;
   logic                                if_rvalid;
   logic [niu32_pkg::WORD_SIZE-1:0]     if_rdata;

   logic                                d_req;
   logic                                d_we;
   logic [niu32_pkg::WORD_SIZE-1:0]     d_addr;
   logic [niu32_pkg::WORD_SIZE-1:0]     d_wdata;
   logic                                d_gnt;
   logic                                d_rvalid;
   logic [niu32_pkg::WORD_SIZE-1:0]     d_rdata;

   logic                                mem_en;
   logic                                mem_we;
   logic [niu32_pkg::WIDX_BITS-1:0]     mem_addr;
   logic [niu32_pkg::WORD_SIZE-1:0]     mem_wdata;
   logic [niu32_pkg::WORD_SIZE-1:0]     mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/niu32_arb_pick.sv
// Winner select for the arbiter: data beats fetch; with NIU32_ARB_STARVE_EN
// defined, fetch is forced through after STARVE_MAX consecutive data grants.
module niu32_arb_pick
`ifdef NIU32_ARB_STARVE_EN
#(
   parameter int STARVE_MAX = 4
)
`endif
(
`ifdef NIU32_ARB_STARVE_EN
   input  logic clk,
   input  logic reset,
   input  logic arb_ok,
`endif
   input  logic if_req,
   input  logic d_req,
   output logic pick_if,
   output logic pick_d
);

`ifdef NIU32_ARB_STARVE_EN
   localparam int CW = $clog2(STARVE_MAX + 1);

   logic [CW-1:0] starve_cnt;
   logic          starved;

   assign starved = (starve_cnt == CW'(STARVE_MAX));
   assign pick_if = if_req && (!d_req || starved);
   assign pick_d  = d_req && !pick_if;

   always_ff @(posedge clk) begin
      if (reset)
         starve_cnt <= '0;
      else if (!if_req || (arb_ok && pick_if))
         starve_cnt <= '0;
      else if (arb_ok && pick_d)
         starve_cnt <= starve_cnt + 1'b1;
   end
`else
   assign pick_if = if_req && !d_req;
   assign pick_d  = d_req;
`endif

endmodule

// File: rtl/niu32_mem_arbiter.sv
// Single-port memory arbiter between fetch and data requesters, one access in flight.
// Optional fetch anti-starvation: NIU32_ARB_STARVE_EN.
//
// state | meaning
// IDLE  | free; grant issued combinationally when any req is present
// WAIT  | read in flight, wait_cnt counts down memory latency
// RESP  | rvalid to owner; arbitrates like IDLE in the same cycle
module niu32_mem_arbiter
   import niu32_pkg::*;
#(
   parameter int MEM_LATENCY = 1
`ifdef NIU32_ARB_STARVE_EN
   ,parameter int STARVE_MAX = 4
`endif
)(
   input  logic                clk,
   input  logic                reset,
   niu32_mem_arbiter_if.slave  bus
);

   localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY - 1);

   arb_state_t            state, state_nx;
   owner_t                owner, owner_nx;
   logic [2:0]            wait_cnt, cnt_nx;
   logic                  arb_ok;
   logic                  pick_if, pick_d;
   logic                  grant_if, grant_d;
   logic                  capture;
   logic [WORD_SIZE-1:0]  sel_addr;
   logic [WORD_SIZE-1:0]  if_rdata_q, d_rdata_q;
   logic                  unused_addr_bits;

   // Grants are suppressed while reset is high so nothing reaches memory.
   assign arb_ok   = !reset && (state != WAIT);
   assign grant_if = arb_ok && pick_if;
   assign grant_d  = arb_ok && pick_d;

   niu32_arb_pick
`ifdef NIU32_ARB_STARVE_EN
   #(
      .STARVE_MAX (STARVE_MAX)
   )
`endif
   u_pick (
`ifdef NIU32_ARB_STARVE_EN
      .clk     (clk),
      .reset   (reset),
      .arb_ok  (arb_ok),
`endif
      .if_req  (bus.if_req),
      .d_req   (bus.d_req),
      .pick_if (pick_if),
      .pick_d  (pick_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= OWN_IF;
         wait_cnt <= '0;
      end else begin
         state    <= state_nx;
         owner    <= owner_nx;
         wait_cnt <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      owner_nx = owner;
      cnt_nx   = wait_cnt;
      case (state)
         IDLE, RESP: begin
            state_nx = IDLE;
            if (grant_d && !bus.d_we) begin
               state_nx = WAIT;
               owner_nx = OWN_D;
               cnt_nx   = LAT_INIT;
            end else if (grant_if) begin
               state_nx = WAIT;
               owner_nx = OWN_IF;
               cnt_nx   = LAT_INIT;
            end
         end
         WAIT: begin
            if (wait_cnt == 3'd0)
               state_nx = RESP;
            else
               cnt_nx = wait_cnt - 3'd1;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign capture = (state == WAIT) && (wait_cnt == 3'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else if (capture) begin
         if (owner == OWN_IF)
            if_rdata_q <= bus.mem_rdata;
         else
            d_rdata_q  <= bus.mem_rdata;
      end
   end

   // Byte offset and bits above the memory window are dropped, so addresses wrap.
   assign sel_addr         = grant_d ? bus.d_addr : bus.if_addr;
   assign unused_addr_bits = ^{sel_addr[WORD_SIZE-1:MEM_ADDR_BITS], sel_addr[1:0]};

   assign bus.if_gnt    = grant_if;
   assign bus.d_gnt     = grant_d;
   assign bus.mem_en    = grant_if || grant_d;
   assign bus.mem_we    = grant_d && bus.d_we;
   assign bus.mem_addr  = (grant_if || grant_d) ? sel_addr[MEM_ADDR_BITS-1:2] : '0;
   assign bus.mem_wdata = (grant_d && bus.d_we) ? bus.d_wdata : '0;

   assign bus.if_rvalid = !reset && (state == RESP) && (owner == OWN_IF);
   assign bus.d_rvalid  = !reset && (state == RESP) && (owner == OWN_D);
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;

endmodule
